// File: rtl/junction_scheduler_if.sv
// Junction scheduler bus: crowd sensors and emergency requests in,
// light outputs and scheduling status out.
interface junction_scheduler_if;
    logic [2:0] S1, S2, S3, S4;
    logic [3:0] emg;
    logic [1:0] T1, T2, T3, T4;
    logic [1:0] active;
    logic [3:0] served;
    logic       phase_done;

    // Environment side: drives sensors/emergency, observes lights.
    modport master (
        output S1, S2, S3, S4, emg,
        input  T1, T2, T3, T4, active, served, phase_done
    );

    // Scheduler side.
    modport slave (
        input  S1, S2, S3, S4, emg,
        output T1, T2, T3, T4, active, served, phase_done
    );
endinterface

// File: rtl/junction_scheduler.sv
// Density-weighted four-road phase scheduler with emergency preemption.
// Each road gets one green per fairness cycle (cycle opens with road 1);
// green length grows with the crowd sensor population count, and any
// emergency request steers the next grant and can cut a foreign green.
module junction_scheduler #(
    parameter int G_BASE  = 4,
    parameter int G_EXT   = 2,
    parameter int Y_TIME  = 3,
    parameter int AR_TIME = 1
) (
    input  logic              clock,
    input  logic              clear,
    junction_scheduler_if.slave js
);

    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
    localparam logic [1:0] ST_ALLRED = 2'd2;

    localparam logic [1:0] L_RED = 2'd0;
    localparam logic [1:0] L_YEL = 2'd1;
    localparam logic [1:0] L_GRN = 2'd2;

    localparam logic [7:0] Y_LOAD  = 8'(Y_TIME - 1);
    localparam logic [7:0] AR_LOAD = 8'(AR_TIME - 1);

    // Population count; any 3-bit code is accepted, not just thermometer.
    function automatic logic [1:0] pop3(input logic [2:0] s);
        return 2'({1'b0, s[0]} + {1'b0, s[1]} + {1'b0, s[2]});
    endfunction

    // Timer load value for a green driven by sensor word s.
    function automatic logic [7:0] gload(input logic [2:0] s);
        int d;
        d = G_BASE + G_EXT * int'(pop3(s)) - 1;
        return d[7:0];
    endfunction

    logic [3:0][2:0] sens;
    assign sens = {js.S4, js.S3, js.S2, js.S1};

    logic [1:0]      state_q, state_d;
    logic [7:0]      tmr_q, tmr_d;
    logic [1:0]      active_q, active_d;
    logic [3:0]      served_q, served_d;
    logic            phase_done_q, phase_done_d;
    logic [3:0][1:0] lights_q, lights_d;

    logic [1:0]      sel_road;
    logic [3:0]      sel_served;
    logic [1:0]      best_pop;
    logic            found;
    logic            emg_other;
    logic            emg_own;

    assign emg_other = |(js.emg & ~(4'b0001 << active_q));
    assign emg_own   = js.emg[active_q];

    // Next-road selection: emergency first, then fairness wrap, then density.
    always_comb begin
        sel_road   = 2'd0;
        sel_served = served_q;
        best_pop   = 2'd0;
        found      = 1'b0;
        if (|js.emg) begin
            for (int i = 3; i >= 0; i--) begin
                if (js.emg[i]) sel_road = 2'(i);
            end
            sel_served = served_q | (4'b0001 << sel_road);
        end else if (&served_q) begin
            sel_road   = 2'd0;
            sel_served = 4'b0001;
        end else begin
            // Strict '>' keeps ties on the lowest index.
            for (int i = 0; i < 4; i++) begin
                if (!served_q[i] && (!found || pop3(sens[i]) > best_pop)) begin
                    found    = 1'b1;
                    best_pop = pop3(sens[i]);
                    sel_road = 2'(i);
                end
            end
            sel_served = served_q | (4'b0001 << sel_road);
        end
    end

    // Phase sequencing and timer.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        active_d     = active_q;
        served_d     = served_q;
        phase_done_d = 1'b0;
        case (state_q)
            ST_GREEN: begin
                if (emg_other) begin
                    // Another road needs the junction: cut green now.
                    state_d = ST_YELLOW;
                    tmr_d   = Y_LOAD;
                end else if (tmr_q == 8'd0) begin
                    if (!emg_own) begin
                        state_d = ST_YELLOW;
                        tmr_d   = Y_LOAD;
                    end
                    // Own emergency: hold green with timer parked at 0.
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            ST_YELLOW: begin
                if (tmr_q == 8'd0) begin
                    state_d = ST_ALLRED;
                    tmr_d   = AR_LOAD;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            ST_ALLRED: begin
                if (tmr_q == 8'd0) begin
                    state_d      = ST_GREEN;
                    active_d     = sel_road;
                    served_d     = sel_served;
                    tmr_d        = gload(sens[sel_road]);
                    phase_done_d = 1'b1;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_ALLRED;
                tmr_d   = AR_LOAD;
            end
        endcase
    end

    // Lights follow the next state so they change on the entering edge.
    always_comb begin
        lights_d = '{default: L_RED};
        for (int i = 0; i < 4; i++) begin
            if (active_d == 2'(i)) begin
                if (state_d == ST_GREEN)       lights_d[i] = L_GRN;
                else if (state_d == ST_YELLOW) lights_d[i] = L_YEL;
            end
        end
    end

    // State registers; reset jumps straight to road 1 green.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= ST_GREEN;
            tmr_q        <= gload(js.S1);
            active_q     <= 2'd0;
            served_q     <= 4'b0001;
            phase_done_q <= 1'b0;
            lights_q     <= {L_RED, L_RED, L_RED, L_GRN};
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            active_q     <= active_d;
            served_q     <= served_d;
            phase_done_q <= phase_done_d;
            lights_q     <= lights_d;
        end
    end

    assign js.T1         = lights_q[0];
    assign js.T2         = lights_q[1];
    assign js.T3         = lights_q[2];
    assign js.T4         = lights_q[3];
    assign js.active     = active_q;
    assign js.served     = served_q;
    assign js.phase_done = phase_done_q;

endmodule

// File: tb/tb_junction_scheduler.sv
// Directed bench for junction_scheduler with default parameters
// (G_BASE=4, G_EXT=2, Y_TIME=3, AR_TIME=1).
module tb_junction_scheduler;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    junction_scheduler_if jif();

    junction_scheduler dut (
        .clock (clock),
        .clear (clear),
        .js    (jif)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] lt(input int road, input logic [1:0] v);
        logic [7:0] r;
        r = 8'h00;
        r[2*(road-1) +: 2] = v;
        return r;
    endfunction

    function automatic logic [7:0] lights();
        return {jif.T4, jif.T3, jif.T2, jif.T1};
    endfunction

    task automatic do_reset();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Checks glen green cycles of road; on return we are in the first yellow.
    task automatic green(input int road, input int glen, input logic [3:0] srv, input bit pd);
        for (int i = 0; i < glen; i++) begin
            check("green_lights", lights(), lt(road, 2'd2));
            check("green_active", jif.active, road - 1);
            check("green_served", jif.served, srv);
            check("phase_done", jif.phase_done, (i == 0) ? pd : 1'b0);
            tick();
        end
    endtask

    // Checks 3 yellow + 1 all-red cycles; on return we are in the next green.
    task automatic clearance(input int road);
        for (int i = 0; i < 3; i++) begin
            check("yellow_lights", lights(), lt(road, 2'd1));
            tick();
        end
        check("allred_lights", lights(), 8'h00);
        tick();
    endtask

    initial begin
        jif.S1 = 3'b000; jif.S2 = 3'b000; jif.S3 = 3'b000; jif.S4 = 3'b000;
        jif.emg = 4'b0000;
        tick();

        // Defaults: order 1,2,3,4,1 with 4-cycle greens.
        do_reset();
        check("reset_lights", lights(), lt(1, 2'd2));
        check("reset_served", jif.served, 4'b0001);
        green(1, 4, 4'b0001, 1'b0); clearance(1);
        green(2, 4, 4'b0011, 1'b1); clearance(2);
        green(3, 4, 4'b0111, 1'b1); clearance(3);
        green(4, 4, 4'b1111, 1'b1); clearance(4);
        check("wrap_lights", lights(), lt(1, 2'd2));
        check("wrap_served", jif.served, 4'b0001);
        check("wrap_pd", jif.phase_done, 1'b1);

        // Density ordering: S1 full at reset, then 3 (10), 4 (8), 2 (6).
        jif.S1 = 3'b111;
        do_reset();
        jif.S2 = 3'b001; jif.S3 = 3'b111; jif.S4 = 3'b011;
        green(1, 10, 4'b0001, 1'b0); clearance(1);
        green(3, 10, 4'b0101, 1'b1); clearance(3);
        green(4, 8, 4'b1101, 1'b1);  clearance(4);
        green(2, 6, 4'b1111, 1'b1);  clearance(2);
        check("dens_wrap_lights", lights(), lt(1, 2'd2));
        check("dens_wrap_served", jif.served, 4'b0001);
        jif.S1 = 3'b000; jif.S2 = 3'b000; jif.S3 = 3'b000; jif.S4 = 3'b000;

        // Preemption from road 4 during cycle 2 of road 2 green.
        do_reset();
        green(1, 4, 4'b0001, 1'b0); clearance(1);
        check("pre_c1", lights(), lt(2, 2'd2));
        tick();
        check("pre_c2", lights(), lt(2, 2'd2));
        jif.emg = 4'b1000;
        tick();
        clearance(2);
        for (int i = 0; i < 15; i++) begin
            check("emg_hold_lights", lights(), lt(4, 2'd2));
            check("emg_hold_served", jif.served, 4'b1011);
            check("emg_hold_pd", jif.phase_done, (i == 0) ? 1'b1 : 1'b0);
            if (i == 14) jif.emg = 4'b0000;
            tick();
        end
        clearance(4);
        check("post_emg_lights", lights(), lt(3, 2'd2));
        check("post_emg_served", jif.served, 4'b1111);
        check("post_emg_active", jif.active, 2'd2);

        // Own-road emergency holds green past expiry.
        do_reset();
        green(1, 4, 4'b0001, 1'b0); clearance(1);
        jif.emg = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            check("own_hold_lights", lights(), lt(2, 2'd2));
            if (i == 9) jif.emg = 4'b0000;
            tick();
        end
        clearance(2);
        check("own_next_lights", lights(), lt(3, 2'd2));
        check("own_next_served", jif.served, 4'b0111);

        // emg=0101 at selection: road 1 again, mask unchanged.
        do_reset();
        green(1, 4, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("sel_yellow", lights(), lt(1, 2'd1));
            tick();
        end
        check("sel_allred", lights(), 8'h00);
        jif.emg = 4'b0101;
        tick();
        jif.emg = 4'b0000;
        check("sel_lights", lights(), lt(1, 2'd2));
        check("sel_active", jif.active, 2'd0);
        check("sel_served", jif.served, 4'b0001);
        check("sel_pd", jif.phase_done, 1'b1);

        // Reset in the 2nd yellow cycle of road 3.
        do_reset();
        green(1, 4, 4'b0001, 1'b0); clearance(1);
        green(2, 4, 4'b0011, 1'b1); clearance(2);
        green(3, 4, 4'b0111, 1'b1);
        check("mid_y1", lights(), lt(3, 2'd1));
        tick();
        check("mid_y2", lights(), lt(3, 2'd1));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("mid_rst_lights", lights(), lt(1, 2'd2));
        check("mid_rst_served", jif.served, 4'b0001);
        check("mid_rst_active", jif.active, 2'd0);
        check("mid_rst_pd", jif.phase_done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
